mem_arbiter: RTL
================

# mem_arbiter

Sequences the single byte-wide main-memory port between the instruction-cache refill path and the load/store unit. It turns an instruction-cache miss into a burst of byte reads and delivers a full block for the cache's write port. It turns LSU requests into 1/2/4-byte read or write sequences. It sits between the fetch/LSU units and the top-level RAM interface, and it is the only driver of the memory address, data-out and write-enable lines.

## Interface
- BLOCK_BYTES, 16, instruction-cache block size in bytes (power of two, ≥4); if_block width = 8·BLOCK_BYTES
- clk_in  in  1  clock; all logic on rising edge
- rst_in  in  1  synchronous, active-high reset
- rdy_in  in  1  global ready; logic pauses when low
- mem_din  in  8  RAM read data; valid one cycle after its address
- mem_dout  out  8  RAM write data
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write this cycle, 0 = read
- if_req  in  1  refill request; held until if_done
- if_addr  in  32  miss address; low log2(BLOCK_BYTES) bits ignored
- if_flush  in  1  abandon any refill (branch redirect)
- if_done  out  1  one-cycle pulse; if_block valid this cycle
- if_block  out  8·BLOCK_BYTES  refilled block, byte k at bits [8k+7:8k]
- ls_req  in  1  LSU request; held until ls_done
- ls_wr  in  1  1 = store, 0 = load
- ls_len  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is illegal and treated as 4
- ls_addr  in  32  first byte address; no alignment requirement
- ls_wdata  in  32  store data, little-endian
- ls_done  out  1  one-cycle pulse; ls_rdata valid this cycle for loads
- ls_rdata  out  32  load data, zero-extended, little-endian

## Operation
- States: IDLE, IF_READ, LS_READ, LS_WRITE, DONE.
- IDLE:
  - Samples requests. Picks the winner per the arbitration policy (see Configuration).
  - Latches the address, length and write data, clears the byte counter k, and moves to the granted state.
- IF_READ:
  - Drives mem_a = block base + k.
  - Captures mem_din from the previous address into byte k−1.
  - After BLOCK_BYTES addresses have been issued and the last byte has been captured, moves to DONE.
- LS_READ: same as IF_READ, over n = 1, 2 or 4 bytes starting at ls_addr.
- LS_WRITE:
  - Drives mem_wr = 1, mem_a = ls_addr + k, mem_dout = ls_wdata[8k+7:8k], for k = 0..n−1.
  - Then moves to DONE.
- DONE:
  - Pulses the matching done signal for one cycle and returns to IDLE.
  - New requests are not sampled in this cycle.
- Addresses wrap modulo 2^32.
- if_flush:
  - Any IF_READ cycle with if_flush high goes to IDLE next cycle. No if_done is produced and partial data is discarded.
  - if_req is ignored in IDLE while if_flush is high.
  - if_flush has no effect on LS_READ or LS_WRITE.
- rdy_in low:
  - State, counters and captured data hold.
  - mem_wr is forced to 0.
  - A read byte in flight is discarded and re-addressed when rdy_in returns high.
- Outputs when not transferring: mem_wr = 0, mem_a = 0, mem_dout = 0.
- Reset (also mid-operation):
  - State = IDLE, k = 0; every output = 0, including if_block and ls_rdata.
  - Round-robin pointer "last" = IF.
  - No write is issued in the reset cycle.

## Timing
- Grant happens in IDLE cycle G.
- Read of n bytes:
  - Addresses are issued in cycles G+1..G+n.
  - Bytes are captured at the ends of cycles G+2..G+n+1.
  - done is high in cycle G+n+2.
  - Refill with BLOCK_BYTES = 16: if_done at G+18. Word load: ls_done at G+6.
- Write of n bytes:
  - Writes occur in cycles G+1..G+n.
  - ls_done is high in cycle G+n+1.
  - Word store: ls_done at G+5.
- Earliest next grant is at G+n+3 for reads and G+n+2 for writes.
- Requesters must drop req in the cycle after done, or they are re-granted.
- if_block and ls_rdata hold their values after done until the next completion of the same type.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - On simultaneous if_req and ls_req, the requester not granted last wins.
  - "last" updates on every grant.
  - From reset, LSU wins the first tie.
- Undefined: fixed priority; LSU always beats instruction fetch, so instruction fetch can starve while LSU traffic persists.

## Test plan
- Refill: if_addr = 0x1234 with RAM byte[a] = a[7:0] → base 0x1230, mem_a = 0x1230..0x123F in G+1..G+16, if_done at G+18, if_block byte k = 0x30+k.
- Store then load:
  - ls_wr = 1, len = 2, addr = 0x0003, wdata = 0xDEADBEEF → writes EF, BE, AD, DE to 0x3..0x6, ls_done at G+5.
  - Then load len = 1 at 0x4 → ls_rdata = 0x0000ADBE at G+4.
- Tie: if_req and ls_req both high in the same cycle after reset:
  - MEM_ARB_RR_EN defined → LSU is granted first, then the refill.
  - Undefined → LSU is granted first both times when ls_req is re-raised immediately.
- Flush: if_flush high at G+7 of a refill → IDLE next cycle, no if_done; a concurrent pending ls_req is granted in that IDLE cycle.
- rdy_in low for 3 cycles during byte 2 of a word store → mem_wr = 0 while low, no duplicate or skipped byte, ls_done delayed by exactly 3 cycles.
- rst_in high mid-refill → next cycle all outputs 0, state IDLE; a fresh if_req completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences the byte-wide RAM port for I-cache refills and LSU accesses.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the LSU has fixed priority.
module mem_arbiter #(
    parameter int BLOCK_BYTES = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic [7:0]               mem_din,
    output logic [7:0]               mem_dout,
    output logic [31:0]              mem_a,
    output logic                     mem_wr,
    input  logic                     if_req,
    input  logic [31:0]              if_addr,
    input  logic                     if_flush,
    output logic                     if_done,
    output logic [8*BLOCK_BYTES-1:0] if_block,
    input  logic                     ls_req,
    input  logic                     ls_wr,
    input  logic [1:0]               ls_len,
    input  logic [31:0]              ls_addr,
    input  logic [31:0]              ls_wdata,
    output logic                     ls_done,
    output logic [31:0]              ls_rdata
);

    localparam int OFF = $clog2(BLOCK_BYTES);
    localparam int CW  = OFF + 1;
    localparam int BW  = 8 * BLOCK_BYTES;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_IF_READ  = 3'd1;
    localparam logic [2:0] S_LS_READ  = 3'd2;
    localparam logic [2:0] S_LS_WRITE = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] idx;
    logic [CW-1:0] ls_n;
    logic          vld_q, vld_d;
    logic          is_if_q, is_if_d;
    logic [31:0]   base_q, base_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [BW-1:0] buf_q, buf_d, cap;
    logic [BW-1:0] blk_q, blk_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          if_ok, gnt_if, gnt_ls;

    assign if_ok = if_req && !if_flush;

`ifdef MEM_ARB_RR_EN
    logic last_ls_q;

    // Tie goes to whoever did not win the previous grant.
    assign gnt_ls = ls_req && !(if_ok && last_ls_q);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_ls_q <= 1'b0;
        end else if (rdy_in && state_q == S_IDLE && (gnt_ls || gnt_if)) begin
            last_ls_q <= gnt_ls;
        end
    end
`else
    assign gnt_ls = ls_req;
`endif

    assign gnt_if = if_ok && !gnt_ls;

    always_comb begin
        ls_n = CW'(4);
        unique case (ls_len)
            2'd0:    ls_n = CW'(1);
            2'd1:    ls_n = CW'(2);
            default: ls_n = CW'(4);
        endcase
    end

    // cnt_q counts captured bytes; vld_q marks a read whose data lands this cycle.
    assign idx = cnt_q + {{(CW-1){1'b0}}, vld_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        vld_d    = vld_q;
        is_if_d  = is_if_q;
        base_d   = base_q;
        wdata_d  = wdata_q;
        buf_d    = buf_q;
        blk_d    = blk_q;
        rdata_d  = rdata_q;
        mem_a    = 32'd0;
        mem_wr   = 1'b0;
        mem_dout = 8'd0;
        if_done  = 1'b0;
        ls_done  = 1'b0;
        cap      = buf_q;
        cap[{cnt_q[OFF-1:0], 3'b000} +: 8] = mem_din;

        if (rdy_in && !rst_in) begin
            unique case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    vld_d = 1'b0;
                    buf_d = '0;
                    if (gnt_ls) begin
                        base_d  = ls_addr;
                        len_d   = ls_n;
                        wdata_d = ls_wdata;
                        is_if_d = 1'b0;
                        state_d = ls_wr ? S_LS_WRITE : S_LS_READ;
                    end else if (gnt_if) begin
                        base_d  = if_addr & ~(32'(BLOCK_BYTES) - 32'd1);
                        len_d   = CW'(BLOCK_BYTES);
                        is_if_d = 1'b1;
                        state_d = S_IF_READ;
                    end
                end
                S_IF_READ, S_LS_READ: begin
                    if (state_q == S_IF_READ && if_flush) begin
                        vld_d   = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        vld_d = idx < len_q;
                        if (idx < len_q) begin
                            mem_a = base_q + 32'(idx);
                        end
                        if (vld_q) begin
                            buf_d = cap;
                            cnt_d = cnt_q + ONE;
                            if (cnt_q == len_q - ONE) begin
                                state_d = S_DONE;
                                if (is_if_q) begin
                                    blk_d = cap;
                                end else begin
                                    rdata_d = cap[31:0];
                                end
                            end
                        end
                    end
                end
                S_LS_WRITE: begin
                    mem_wr   = 1'b1;
                    mem_a    = base_q + 32'(cnt_q);
                    mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    cnt_d    = cnt_q + ONE;
                    if (cnt_q == len_q - ONE) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if_done = is_if_q;
                    ls_done = !is_if_q;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            // A read issued before a stall is dropped and re-addressed.
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            vld_q   <= 1'b0;
            is_if_q <= 1'b0;
            base_q  <= 32'd0;
            wdata_q <= 32'd0;
            buf_q   <= '0;
            blk_q   <= '0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            vld_q   <= vld_d;
            is_if_q <= is_if_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            blk_q   <= blk_d;
            rdata_q <= rdata_d;
        end
    end

    assign if_block = blk_q;
    assign ls_rdata = rdata_q;

endmodule
